// File: rtl/id_ex_pipe_reg.sv
// ID->EX pipeline register with load-use hazard detection, bubble insertion,
// flush/hold handling and a saturating count of load-use bubbles.
module id_ex_pipe_reg #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             hold,
  input  logic             flush,
  input  logic             id_valid,
  input  logic [XLEN-1:0]  id_pc,
  input  logic [XLEN-1:0]  id_rs1_data,
  input  logic [XLEN-1:0]  id_rs2_data,
  input  logic [XLEN-1:0]  id_imm,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic [4:0]       id_rd,
  input  logic [2:0]       id_funct3,
  input  logic [6:0]       id_funct7,
  input  logic [2:0]       id_alu_op,
  input  logic [6:0]       id_ctrl,
  output logic             stall_id,
  output logic             ex_valid,
  output logic [XLEN-1:0]  ex_pc,
  output logic [XLEN-1:0]  ex_rs1_data,
  output logic [XLEN-1:0]  ex_rs2_data,
  output logic [XLEN-1:0]  ex_imm,
  output logic [4:0]       ex_rs1,
  output logic [4:0]       ex_rs2,
  output logic [4:0]       ex_rd,
  output logic [2:0]       ex_funct3,
  output logic [6:0]       ex_funct7,
  output logic [2:0]       ex_alu_op,
  output logic [6:0]       ex_ctrl,
  output logic [CNT_W-1:0] bubble_cnt
);

  // ctrl = {alu_src, mem_read, mem_write, reg_write, mem_to_reg, branch, jump}
  localparam int MEM_READ_BIT = 5;

  logic             luh;
  logic             load_bubble;
  logic             count_bubble;
  logic [CNT_W-1:0] bubble_cnt_next;

  // Index-only compare: an instruction that does not really read rs2 may stall needlessly.
  assign luh = ex_valid & ex_ctrl[MEM_READ_BIT] & (ex_rd != 5'd0) & id_valid
               & ((ex_rd == id_rs1) | (ex_rd == id_rs2));

  assign stall_id     = (luh & ~flush) | hold;
  assign load_bubble  = flush | luh;
  assign count_bubble = luh & ~flush;

  always_comb begin
    bubble_cnt_next = bubble_cnt;
    if (count_bubble && (bubble_cnt != {CNT_W{1'b1}})) begin
      bubble_cnt_next = bubble_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ex_valid    <= 1'b0;
      ex_pc       <= '0;
      ex_rs1_data <= '0;
      ex_rs2_data <= '0;
      ex_imm      <= '0;
      ex_rs1      <= '0;
      ex_rs2      <= '0;
      ex_rd       <= '0;
      ex_funct3   <= '0;
      ex_funct7   <= '0;
      ex_alu_op   <= '0;
      ex_ctrl     <= '0;
      bubble_cnt  <= '0;
    end else if (!hold) begin
      bubble_cnt <= bubble_cnt_next;
      if (load_bubble) begin
        // Zeroed indices keep forwarding logic from ever matching a bubble.
        ex_valid    <= 1'b0;
        ex_pc       <= '0;
        ex_rs1_data <= '0;
        ex_rs2_data <= '0;
        ex_imm      <= '0;
        ex_rs1      <= '0;
        ex_rs2      <= '0;
        ex_rd       <= '0;
        ex_funct3   <= '0;
        ex_funct7   <= '0;
        ex_alu_op   <= '0;
        ex_ctrl     <= '0;
      end else begin
        ex_valid    <= id_valid;
        ex_pc       <= id_pc;
        ex_rs1_data <= id_rs1_data;
        ex_rs2_data <= id_rs2_data;
        ex_imm      <= id_imm;
        ex_rs1      <= id_rs1;
        ex_rs2      <= id_rs2;
        ex_rd       <= id_rd;
        ex_funct3   <= id_funct3;
        ex_funct7   <= id_funct7;
        ex_alu_op   <= id_alu_op;
        ex_ctrl     <= id_ctrl;
      end
    end
  end

endmodule
